// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive controller:
//   - rx_state_e    : 3-bit Gray-style FSM state encoding
//   - rx_en_t       : bundle of the block enables driven by the controller
//   - PRESC_*       : legal oversampling ratios
//   - MIN/MAX_DATA_WIDTH : legal data-bit range per frame
//   - state_enables : Moore decode of the enables from a state
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    // Neighbouring states along the normal frame path differ in one bit.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b011,
        ST_PARITY = 3'b010,
        ST_STOP   = 3'b110,
        ST_BREAK  = 3'b111
    } rx_state_e;

    localparam int unsigned PRESC_8        = 32'd8;
    localparam int unsigned PRESC_16       = 32'd16;
    localparam int unsigned PRESC_32       = 32'd32;
    localparam int unsigned MIN_DATA_WIDTH = 32'd5;
    localparam int unsigned MAX_DATA_WIDTH = 32'd9;

    typedef struct packed {
        logic data_sample_en;
        logic edge_cnt_en;
        logic strt_check_en;
        logic par_check_en;
        logic stp_check_en;
        logic deserializer_en;
    } rx_en_t;

    // Enables are a pure function of the state; IDLE and BREAK keep all off.
    function automatic rx_en_t state_enables(input rx_state_e st);
        rx_en_t en;
        en = '0;
        case (st)
            ST_START: begin
                en.data_sample_en = 1'b1;
                en.edge_cnt_en    = 1'b1;
                en.strt_check_en  = 1'b1;
            end
            ST_DATA: begin
                en.data_sample_en  = 1'b1;
                en.edge_cnt_en     = 1'b1;
                en.deserializer_en = 1'b1;
            end
            ST_PARITY: begin
                en.data_sample_en = 1'b1;
                en.edge_cnt_en    = 1'b1;
                en.par_check_en   = 1'b1;
            end
            ST_STOP: begin
                en.data_sample_en = 1'b1;
                en.edge_cnt_en    = 1'b1;
                en.stp_check_en   = 1'b1;
            end
            default: begin
                en = '0;
            end
        endcase
        return en;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
// Bundles the serial line, runtime configuration, checker results, block
// enables, counters and status pulses of the UART receive controller.
//   slave  : the controller (consumes line/config/checker results)
//   master : the surrounding RX path (drives line/config/checker results)
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
    parameter int PRESC_W = 6
);
    logic               rx_in;
    logic [PRESC_W-1:0] prescale;
    logic               par_en;
    logic               par_typ;
    logic               stp2_en;
    logic               strt_glitch;
    logic               par_err;
    logic               stp_err;

    logic               data_sample_en;
    logic               edge_cnt_en;
    logic               strt_check_en;
    logic               par_check_en;
    logic               stp_check_en;
    logic               deserializer_en;
    logic [PRESC_W-1:0] edge_cnt;
    logic [3:0]         bit_cnt;
    logic               par_typ_lat;
    logic               data_valid;
    logic               par_err_o;
    logic               frame_err;
    logic               break_det;

    modport slave (
        input  rx_in, prescale, par_en, par_typ, stp2_en,
               strt_glitch, par_err, stp_err,
        output data_sample_en, edge_cnt_en, strt_check_en, par_check_en,
               stp_check_en, deserializer_en, edge_cnt, bit_cnt,
               par_typ_lat, data_valid, par_err_o, frame_err, break_det
    );

    modport master (
        output rx_in, prescale, par_en, par_typ, stp2_en,
               strt_glitch, par_err, stp_err,
        input  data_sample_en, edge_cnt_en, strt_check_en, par_check_en,
               stp_check_en, deserializer_en, edge_cnt, bit_cnt,
               par_typ_lat, data_valid, par_err_o, frame_err, break_det
    );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// ---------------------------------------------------------------------------
// uart_rx_edge_bit_cnt
// Oversampling edge counter and frame bit counter.
//   clk, rst         : clock, asynchronous active-low reset
//   i_enable         : count edges this cycle
//   i_clear          : force both counters to 0 (wins over counting)
//   i_prescale_lat   : edges per bit
//   o_edge_cnt       : edge index within the current bit
//   o_bit_cnt        : bit index within the frame (start bit = 0)
//   o_bit_done       : this cycle is the last edge of the current bit
// ---------------------------------------------------------------------------
module uart_rx_edge_bit_cnt #(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable,
    input  logic               i_clear,
    input  logic [PRESC_W-1:0] i_prescale_lat,
    output logic [PRESC_W-1:0] o_edge_cnt,
    output logic [3:0]         o_bit_cnt,
    output logic               o_bit_done
);

    logic [PRESC_W-1:0] r_edge_cnt;
    logic [3:0]         r_bit_cnt;
    logic               w_last_edge;

    // An illegal prescale of 0 makes the wrap point all-ones, so the counter
    // still stays within its own width.
    assign w_last_edge = (r_edge_cnt == (i_prescale_lat - PRESC_W'(1'b1)));
    assign o_bit_done  = i_enable & w_last_edge;
    assign o_edge_cnt  = r_edge_cnt;
    assign o_bit_cnt   = r_bit_cnt;

    // Edge/bit counting with clear taking priority over the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= 4'd0;
        end else if (i_clear) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= 4'd0;
        end else if (o_bit_done) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
        end else if (i_enable) begin
            r_edge_cnt <= r_edge_cnt + PRESC_W'(1'b1);
        end else begin
            r_edge_cnt <= r_edge_cnt;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-path controller: frame FSM, configuration latch, all-zero data
// tracking for break detection, and single-cycle status pulses.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : uart_rx_ctrl_if.slave -- line, config and checker results in;
//          block enables, edge/bit counters, latched parity type and
//          status pulses (data_valid, par_err_o, frame_err, break_det) out
// ---------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_ctrl_if.slave bus
);

    localparam logic [3:0] DATA_BITS = 4'(DATA_WIDTH);

    rx_state_e          r_state;
    rx_state_e          w_state_nxt;
    rx_en_t             r_en;
    logic [PRESC_W-1:0] r_prescale_lat;
    logic               r_par_en_lat;
    logic               r_par_typ_lat;
    logic               r_stp2_en_lat;
    logic               r_all_zero;
    logic               r_data_valid;
    logic               r_par_err_o;
    logic               r_frame_err;
    logic               r_break_det;

    logic [PRESC_W-1:0] w_edge_cnt;
    logic [3:0]         w_bit_cnt;
    logic               w_bit_done;
    logic               w_cnt_clr;
    logic               w_cfg_latch;
    logic               w_mid_one;
    logic               w_frame_end;
    logic               w_break;
    logic [3:0]         w_last_stop_idx;

    uart_rx_edge_bit_cnt #(
        .PRESC_W (PRESC_W)
    ) u_cnt (
        .clk            (clk),
        .rst            (rst),
        .i_enable       (r_en.edge_cnt_en),
        .i_clear        (w_cnt_clr),
        .i_prescale_lat (r_prescale_lat),
        .o_edge_cnt     (w_edge_cnt),
        .o_bit_cnt      (w_bit_cnt),
        .o_bit_done     (w_bit_done)
    );

    // Bit index of the final stop bit: start(0), data(1..N), optional parity, stop(s).
    assign w_last_stop_idx = DATA_BITS + 4'd1 + {3'd0, r_par_en_lat} + {3'd0, r_stp2_en_lat};

    // Next-state decision and end-of-frame classification.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = 1'b0;
        w_break     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.rx_in) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    if (bus.strt_glitch) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (w_bit_done && (w_bit_cnt == DATA_BITS)) begin
                    if (r_par_en_lat) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_state_nxt = ST_STOP;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_nxt = ST_STOP;
                end else begin
                    w_state_nxt = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (w_bit_done && (w_bit_cnt == w_last_stop_idx)) begin
                    w_frame_end = 1'b1;
                    // A line held low through an all-zero frame is a break, not a frame error.
                    if (r_all_zero && bus.stp_err && !bus.rx_in) begin
                        w_break     = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end else if (!bus.rx_in) begin
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (bus.rx_in) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BREAK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame entry (from IDLE or straight out of STOP) latches config and restarts counting.
    assign w_cfg_latch = (w_state_nxt == ST_START) && (r_state != ST_START);
    assign w_cnt_clr   = w_cfg_latch || (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_BREAK);

    // A data bit sampled high at mid-bit means the frame is not all zeros.
    assign w_mid_one = (r_state == ST_DATA) && r_en.edge_cnt_en && bus.rx_in &&
                       (w_edge_cnt == (r_prescale_lat >> 1));

    // State, registered enables, config latch, zero flag and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_en           <= '0;
            r_prescale_lat <= '0;
            r_par_en_lat   <= 1'b0;
            r_par_typ_lat  <= 1'b0;
            r_stp2_en_lat  <= 1'b0;
            r_all_zero     <= 1'b0;
            r_data_valid   <= 1'b0;
            r_par_err_o    <= 1'b0;
            r_frame_err    <= 1'b0;
            r_break_det    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= state_enables(w_state_nxt);

            if (w_cfg_latch) begin
                r_prescale_lat <= bus.prescale;
                r_par_en_lat   <= bus.par_en;
                r_par_typ_lat  <= bus.par_typ;
                r_stp2_en_lat  <= bus.stp2_en;
            end

            if (w_cfg_latch) begin
                r_all_zero <= 1'b1;
            end else if (w_mid_one) begin
                r_all_zero <= 1'b0;
            end

            // Exactly one pulse per completed frame; parity error outranks frame error.
            r_data_valid <= w_frame_end && !w_break && !bus.par_err && !bus.stp_err;
            r_par_err_o  <= w_frame_end && !w_break && bus.par_err;
            r_frame_err  <= w_frame_end && !w_break && bus.stp_err && !bus.par_err;
            r_break_det  <= w_break;
        end
    end

    assign bus.data_sample_en  = r_en.data_sample_en;
    assign bus.edge_cnt_en     = r_en.edge_cnt_en;
    assign bus.strt_check_en   = r_en.strt_check_en;
    assign bus.par_check_en    = r_en.par_check_en;
    assign bus.stp_check_en    = r_en.stp_check_en;
    assign bus.deserializer_en = r_en.deserializer_en;
    assign bus.edge_cnt        = w_edge_cnt;
    assign bus.bit_cnt         = w_bit_cnt;
    assign bus.par_typ_lat     = r_par_typ_lat;
    assign bus.data_valid      = r_data_valid;
    assign bus.par_err_o       = r_par_err_o;
    assign bus.frame_err       = r_frame_err;
    assign bus.break_det       = r_break_det;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed frames drive the serial line cycle by cycle; every frame pushes
// its expected status pulse (kind and cycle) into a scoreboard queue, and a
// monitor on the falling edge pops and compares whenever a pulse appears.
// Pulse vector order: {break_det, frame_err, par_err_o, data_valid}.
// Enable vector order: {data_sample_en, edge_cnt_en, strt_check_en,
//                       par_check_en, stp_check_en, deserializer_en}.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam logic [31:0] EN_NONE   = 32'b000000;
    localparam logic [31:0] EN_START  = 32'b111000;
    localparam logic [31:0] EN_DATA   = 32'b110001;
    localparam logic [31:0] EN_PARITY = 32'b110100;
    localparam logic [31:0] EN_STOP   = 32'b110010;

    localparam logic [3:0] P_NONE  = 4'b0000;
    localparam logic [3:0] P_VALID = 4'b0001;
    localparam logic [3:0] P_PERR  = 4'b0010;
    localparam logic [3:0] P_FERR  = 4'b0100;
    localparam logic [3:0] P_BREAK = 4'b1000;

    typedef struct {
        logic [3:0] p;
        int         c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   s_glitch;
    int   s_break;

    uart_rx_ctrl_if #(.PRESC_W(6)) bus ();

    uart_rx_ctrl #(
        .DATA_WIDTH (8),
        .PRESC_W    (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [5:0] w_en;
    logic [3:0] w_pulse;
    assign w_en    = {bus.data_sample_en, bus.edge_cnt_en, bus.strt_check_en,
                      bus.par_check_en, bus.stp_check_en, bus.deserializer_en};
    assign w_pulse = {bus.break_det, bus.frame_err, bus.par_err_o, bus.data_valid};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (w_pulse !== P_NONE) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got %b expected none (cycle %0d)", w_pulse, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pulse_kind", 32'(w_pulse), 32'(mon_e.p));
                chk("pulse_cycle", cyc, mon_e.c);
            end
        end
    end

    task automatic idle(input int n);
        bus.rx_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame (8 data bits, LSB first). With pre=1 the line drops one
    // cycle before START (the IDLE detection cycle). The last cycle is driven
    // low only when another frame follows back-to-back; otherwise high so a
    // bad (low) stop bit does not itself start a new frame.
    task automatic send_frame(input logic [7:0] data, input int psc,
                              input logic par, input logic par_bit, input logic stp2,
                              input logic stop_val, input logic pre, input logic b2b_next,
                              input logic [3:0] exp_p,
                              input int chg_at, input logic [5:0] chg_val,
                              input int chg2_at, input logic [5:0] chg2_val,
                              input int abort_at);
        logic [12:0] fb;
        int          s;
        int          nbits;
        int          len;
        int          idx;
        if (pre) begin
            bus.rx_in = 1'b0;
            @(posedge clk);
            #1;
        end
        s     = cyc;
        nbits = 10 + int'(par) + int'(stp2);
        len   = psc * nbits;
        fb    = '1;
        fb[0] = 1'b0;
        for (int k = 0; k < 8; k++) fb[1 + k] = data[k];
        idx = 9;
        if (par) begin
            fb[idx] = par_bit;
            idx++;
        end
        fb[idx] = stop_val;
        if (stp2) fb[idx + 1] = stop_val;
        if (exp_p != P_NONE) sb_q.push_back('{p: exp_p, c: s + len});
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
                chk("abort_bit_cnt", 32'(bus.bit_cnt), 32'd4);
                rst = 1'b0;
                #1;
                chk("abort_enables", 32'(w_en), EN_NONE);
                chk("abort_edge_cnt", 32'(bus.edge_cnt), 32'd0);
                chk("abort_bit_cnt_zero", 32'(bus.bit_cnt), 32'd0);
                chk("abort_par_typ_lat", 32'(bus.par_typ_lat), 32'd0);
                chk("abort_pulses", 32'(w_pulse), 32'(P_NONE));
                bus.rx_in = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b1;
                return;
            end
            if (i == chg_at)  bus.prescale = chg_val;
            if (i == chg2_at) bus.prescale = chg2_val;
            if (i == 0) begin
                chk("start_enables", 32'(w_en), EN_START);
                chk("start_edge_cnt", 32'(bus.edge_cnt), 32'd0);
                chk("start_bit_cnt", 32'(bus.bit_cnt), 32'd0);
            end
            if (i == 2 * psc + psc / 2) begin
                chk("data_enables", 32'(w_en), EN_DATA);
                chk("data_bit_cnt", 32'(bus.bit_cnt), 32'd2);
                chk("data_edge_cnt", 32'(bus.edge_cnt), psc / 2);
            end
            if (par && (i == 9 * psc)) chk("parity_enables", 32'(w_en), EN_PARITY);
            if (i == len - 1) begin
                chk("stop_enables", 32'(w_en), EN_STOP);
                chk("stop_bit_cnt", 32'(bus.bit_cnt), nbits - 1);
                bus.rx_in = b2b_next ? 1'b0 : 1'b1;
            end else begin
                bus.rx_in = fb[i / psc];
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.rx_in       = 1'b1;
        bus.prescale    = 6'd8;
        bus.par_en      = 1'b1;
        bus.par_typ     = 1'b0;
        bus.stp2_en     = 1'b0;
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;
        rst             = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enables", 32'(w_en), EN_NONE);
        chk("rst_edge_cnt", 32'(bus.edge_cnt), 32'd0);
        chk("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        chk("rst_par_typ_lat", 32'(bus.par_typ_lat), 32'd0);
        chk("rst_pulses", 32'(w_pulse), 32'(P_NONE));
        rst = 1'b1;
        idle(4);

        // 0xA5, even parity bit 0, prescale 8: 11 bits -> pulse 88 cycles after START entry.
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P_VALID, -1, 6'd0, -1, 6'd0, -1);
        chk("par_typ_lat_even", 32'(bus.par_typ_lat), 32'd0);
        idle(4);

        // 0x3C odd parity: correct bit is 1, send 0 with the checker flagging it.
        bus.par_typ = 1'b1;
        bus.par_err = 1'b1;
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P_PERR, -1, 6'd0, -1, 6'd0, -1);
        chk("par_typ_lat_odd", 32'(bus.par_typ_lat), 32'd1);
        idle(4);

        // Correct parity, stop bit 0 -> frame error only.
        bus.par_err = 1'b0;
        bus.stp_err = 1'b1;
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, P_FERR, -1, 6'd0, -1, 6'd0, -1);
        idle(4);

        // Both errors: parity error wins.
        bus.par_err = 1'b1;
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, P_PERR, -1, 6'd0, -1, 6'd0, -1);
        bus.par_err = 1'b0;
        bus.stp_err = 1'b0;
        bus.par_typ = 1'b0;
        idle(4);

        // Start glitch at prescale 16: line low 3 cycles, START lasts 16 cycles then IDLE.
        bus.prescale    = 6'd16;
        bus.strt_glitch = 1'b1;
        bus.rx_in       = 1'b0;
        @(posedge clk);
        #1;
        s_glitch = cyc;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                chk("glitch_start_en", 32'(w_en), EN_START);
                chk("glitch_edge0", 32'(bus.edge_cnt), 32'd0);
            end
            if (i == 15) chk("glitch_last_edge", 32'(bus.edge_cnt), 32'd15);
            if (i == 16) begin
                chk("glitch_idle_en", 32'(w_en), EN_NONE);
                chk("glitch_idle_edge", 32'(bus.edge_cnt), 32'd0);
                chk("glitch_idle_bit", 32'(bus.bit_cnt), 32'd0);
                chk("glitch_duration", cyc - s_glitch, 32'd16);
            end
            bus.rx_in = (i < 2) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        bus.strt_glitch = 1'b0;
        idle(4);

        // Back-to-back, prescale 16, parity + 2 stop bits: 12 bits = 192 cycles.
        // Frame 1 sees a prescale change that is undone before its end (no effect);
        // frame 2 sees a change that persists, so frame 3 runs at prescale 8 (96 cycles).
        bus.stp2_en = 1'b1;
        send_frame(8'h55, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, P_VALID, 50, 6'd8, 150, 6'd16, -1);
        send_frame(8'hAA, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, P_VALID, 100, 6'd8, -1, 6'd0, -1);
        send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, P_VALID, -1, 6'd0, -1, 6'd0, -1);
        bus.stp2_en = 1'b0;
        idle(4);

        // Break: line low 12 bit times at prescale 8, no parity (10-bit frame).
        bus.par_en  = 1'b0;
        bus.stp_err = 1'b1;
        bus.rx_in   = 1'b0;
        @(posedge clk);
        #1;
        s_break = cyc;
        sb_q.push_back('{p: P_BREAK, c: s_break + 80});
        for (int i = 0; i < 96; i++) begin
            if (i == 85) begin
                chk("break_hold_en", 32'(w_en), EN_NONE);
                chk("break_hold_edge", 32'(bus.edge_cnt), 32'd0);
                chk("break_hold_bit", 32'(bus.bit_cnt), 32'd0);
            end
            bus.rx_in = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.stp_err = 1'b0;
        bus.par_en  = 1'b1;
        idle(2);
        chk("break_exit_en", 32'(w_en), EN_NONE);
        idle(4);

        // Reset during data bit 4 (cycle 4*8+3 of the frame), then a clean 0x81.
        bus.par_typ = 1'b1;
        send_frame(8'h81, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, P_NONE, -1, 6'd0, -1, 6'd0, 35);
        bus.par_typ = 1'b0;
        idle(4);
        send_frame(8'h81, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P_VALID, -1, 6'd0, -1, 6'd0, -1);
        idle(10);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Run-time bound: the directed sequence needs well under 3000 cycles.
    initial begin
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: got no end of test expected end within 20000 cycles");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
